// File: rtl/edge_buffer_rr_n.sv
// edge_buffer_rr_n: per-channel FIFOs for edge-PE results, drained by a
// work-conserving round-robin arbiter into one registered valid/ready output.
// With PKT_LOCK=1 the grant stays on one channel from the first word of a
// packet until its last word, so packets never interleave at the RS port.
module edge_buffer_rr_n #(
   parameter int NUM_CH   = 4,
   parameter int DW       = 64,
   parameter int DEPTH    = 4,
   parameter int PKT_LOCK = 1,
   parameter int CHW      = $clog2(NUM_CH)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CH-1:0]                      in_valid,
   input  logic [NUM_CH*DW-1:0]                   in_data,
   input  logic [NUM_CH-1:0]                      in_last,
   output logic [NUM_CH-1:0]                      in_ready,
   output logic                                   out_valid,
   output logic [DW-1:0]                          out_data,
   output logic                                   out_last,
   output logic [CHW-1:0]                         out_ch,
   input  logic                                   out_ready,
   output logic                                   busy,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    occ
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0]  FULL_CNT = OW'(DEPTH);
   localparam logic [CHW-1:0] LAST_CH  = CHW'(NUM_CH - 1);

   typedef enum logic {
      LOCK_IDLE,
      LOCK_HELD
   } lock_state_t;

   logic [DW-1:0]     mem_data [NUM_CH][DEPTH];
   logic              mem_last [NUM_CH][DEPTH];
   logic [AW-1:0]     rd_ptr   [NUM_CH];
   logic [AW-1:0]     wr_ptr   [NUM_CH];
   logic [OW-1:0]     cnt      [NUM_CH];

   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] nonempty;
   logic [NUM_CH-1:0] eligible;
   logic [CHW-1:0]    rr_ptr;
   logic [CHW-1:0]    winner;
   logic [CHW-1:0]    cand;
   logic [CHW-1:0]    lock_ch;
   logic [CHW-1:0]    lock_ch_next;
   logic              found;
   logic              load;
   logic              pop_en;
   logic              head_last;
   lock_state_t       lock_state;
   lock_state_t       lock_state_next;

   // FIFO status from registered occupancy; a full FIFO refuses pushes even while being popped
   always_comb begin
      in_ready = '0;
      nonempty = '0;
      push     = '0;
      occ      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready[i]        = (cnt[i] != FULL_CNT);
         nonempty[i]        = (cnt[i] != '0);
         push[i]            = in_valid[i] & in_ready[i];
         occ[i*OW +: OW]    = cnt[i];
      end
   end

   // While a packet holds the lock only its channel may be granted, even if it is momentarily empty
   always_comb begin
      eligible = nonempty;
      if (lock_state == LOCK_HELD) begin
         eligible          = '0;
         eligible[lock_ch] = nonempty[lock_ch];
      end
   end

   // Round-robin search starting one past the last winner, wrapping at NUM_CH
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      cand   = rr_ptr;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = (cand == LAST_CH) ? '0 : cand + CHW'(1);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // A pop happens only when the output register is free or being consumed this cycle
   always_comb begin
      load      = ~out_valid | out_ready;
      pop_en    = load & found;
      head_last = mem_last[winner][rd_ptr[winner]];
      pop       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = pop_en && (winner == CHW'(i));
      end
   end

   // Payload storage has no reset; the pointers and counters below define what is valid
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) begin
            mem_data[i][wr_ptr[i]] <= in_data[i*DW +: DW];
            mem_last[i][wr_ptr[i]] <= in_last[i];
         end
      end
   end

   // FIFO pointers wrap naturally; the occupancy counter tracks fill level separately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            case ({push[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + OW'(1);
               2'b01:   cnt[i] <= cnt[i] - OW'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // Output register and round-robin pointer; both move only on an actual pop, so stalls keep everything stable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= LAST_CH;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else if (load) begin
         out_valid <= found;
         if (found) begin
            out_data <= mem_data[winner][rd_ptr[winner]];
            out_last <= head_last;
            out_ch   <= winner;
            rr_ptr   <= winner;
         end
      end
   end

   // Packet-lock state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_state <= LOCK_IDLE;
         lock_ch    <= '0;
      end else begin
         lock_state <= lock_state_next;
         lock_ch    <= lock_ch_next;
      end
   end

   // Lock on popping a non-last word, release on popping the locked channel's last word
   always_comb begin
      lock_state_next = lock_state;
      lock_ch_next    = lock_ch;
      if ((PKT_LOCK != 0) && pop_en) begin
         case (lock_state)
            LOCK_IDLE: begin
               if (!head_last) begin
                  lock_state_next = LOCK_HELD;
                  lock_ch_next    = winner;
               end
            end
            LOCK_HELD: begin
               if (head_last) lock_state_next = LOCK_IDLE;
            end
            default: lock_state_next = LOCK_IDLE;
         endcase
      end
   end

   // Activity flag for upstream idle detection
   assign busy = (|nonempty) | out_valid;

endmodule

// File: tb/tb_edge_buffer_rr_n.sv
// Testbench for edge_buffer_rr_n: a packet-lock instance and a per-word
// instance share the same stimulus; each is checked against a queue-based
// reference model plus hand-derived expectations for the directed scenarios.
module tb_edge_buffer_rr_n;

   localparam int NUM_CH = 4;
   localparam int DW     = 16;
   localparam int DEPTH  = 4;
   localparam int CHW    = 2;
   localparam int OW     = 3;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DW-1:0]     in_data;
   logic [NUM_CH-1:0]        in_last;
   logic                     out_ready;

   logic [NUM_CH-1:0]        l_in_ready, n_in_ready;
   logic                     l_out_valid, n_out_valid;
   logic [DW-1:0]            l_out_data, n_out_data;
   logic                     l_out_last, n_out_last;
   logic [CHW-1:0]           l_out_ch, n_out_ch;
   logic                     l_busy, n_busy;
   logic [NUM_CH*OW-1:0]     l_occ, n_occ;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: index 0 = packet-lock instance, 1 = per-word instance
   logic [DW:0]     mq [2][NUM_CH][$];
   bit              m_valid [2];
   logic [DW-1:0]   m_data  [2];
   bit              m_last  [2];
   logic [CHW-1:0]  m_ch    [2];
   int              m_rr    [2];
   bit              m_locked[2];
   int              m_lock_ch[2];

   edge_buffer_rr_n #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .PKT_LOCK(1)) dut_lock (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(l_in_ready), .out_valid(l_out_valid), .out_data(l_out_data), .out_last(l_out_last),
      .out_ch(l_out_ch), .out_ready(out_ready), .busy(l_busy), .occ(l_occ));

   edge_buffer_rr_n #(.NUM_CH(NUM_CH), .DW(DW), .DEPTH(DEPTH), .PKT_LOCK(0)) dut_word (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(n_in_ready), .out_valid(n_out_valid), .out_data(n_out_data), .out_last(n_out_last),
      .out_ch(n_out_ch), .out_ready(out_ready), .busy(n_busy), .occ(n_occ));

   always #5 clk = ~clk;

   // a full FIFO must never advertise ready
   always @(negedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            assert (!(l_occ[c*OW +: OW] == OW'(DEPTH) && l_in_ready[c]));
            assert (!(n_occ[c*OW +: OW] == OW'(DEPTH) && n_in_ready[c]));
         end
      end
   end

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < NUM_CH; c++) mq[m][c].delete();
         m_valid[m] = 0; m_data[m] = '0; m_last[m] = 0; m_ch[m] = '0;
         m_rr[m] = NUM_CH - 1; m_locked[m] = 0; m_lock_ch[m] = 0;
      end
   endtask

   task automatic model_step(input int m);
      bit rdy [NUM_CH];
      bit got;
      int c;
      logic [DW:0] w;
      for (int i = 0; i < NUM_CH; i++) rdy[i] = (mq[m][i].size() < DEPTH);
      if (!m_valid[m] || out_ready) begin
         got = 0;
         for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_rr[m] + k) % NUM_CH;
            if (!got && mq[m][c].size() > 0 && (!m_locked[m] || c == m_lock_ch[m])) begin
               got = 1;
               w = mq[m][c].pop_front();
               m_data[m] = w[DW-1:0];
               m_last[m] = w[DW];
               m_ch[m]   = CHW'(c);
               m_rr[m]   = c;
               if (m == 0) begin
                  if (!m_locked[m] && !w[DW]) begin
                     m_locked[m] = 1; m_lock_ch[m] = c;
                  end else if (m_locked[m] && w[DW]) begin
                     m_locked[m] = 0;
                  end
               end
            end
         end
         m_valid[m] = got;
      end
      for (int i = 0; i < NUM_CH; i++)
         if (in_valid[i] && rdy[i]) mq[m][i].push_back({in_last[i], in_data[i*DW +: DW]});
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) begin
         model_step(0);
         model_step(1);
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
      reset = 1'b0;
      model_reset();
      #2;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      n_tests++;
      if ({l_out_valid, l_out_data, l_out_last, l_out_ch, l_busy} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_out_lock got v=%0b d=%h l=%0b ch=%0d busy=%0b, expected all 0", l_out_valid, l_out_data, l_out_last, l_out_ch, l_busy);
      end
      n_tests++;
      if ({n_out_valid, n_out_data, n_out_last, n_out_ch, n_busy} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_out_word got v=%0b d=%h l=%0b ch=%0d busy=%0b, expected all 0", n_out_valid, n_out_data, n_out_last, n_out_ch, n_busy);
      end
      n_tests++;
      if (l_occ !== '0 || n_occ !== '0 || l_in_ready !== 4'hF || n_in_ready !== 4'hF) begin
         n_fail++;
         $display("[TB] FAIL reset_fifo got occ=%h/%h rdy=%h/%h, expected occ=0 rdy=f", l_occ, n_occ, l_in_ready, n_in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single_word();
      do_reset();
      out_ready = 1'b1;
      in_valid = 4'b0100; in_last = 4'b0100; in_data = '0; in_data[2*DW +: DW] = 16'h00A5;
      step();
      in_valid = '0; in_last = '0;
      n_tests++;
      if (l_out_valid !== 1'b0) begin
         n_fail++; $display("[TB] FAIL single_early got out_valid=%0b, expected 0", l_out_valid);
      end
      step();
      n_tests++;
      if (l_out_valid !== 1'b1 || l_out_ch !== 2'd2 || l_out_data !== 16'h00A5 || l_out_last !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL single_word got v=%0b ch=%0d d=%h l=%0b, expected v=1 ch=2 d=00a5 l=1", l_out_valid, l_out_ch, l_out_data, l_out_last);
      end
      n_tests++;
      if (l_busy !== 1'b1) begin
         n_fail++; $display("[TB] FAIL single_busy_hold got busy=%0b, expected 1", l_busy);
      end
      step();
      n_tests++;
      if (l_out_valid !== 1'b0 || l_busy !== 1'b0) begin
         n_fail++; $display("[TB] FAIL single_drain got v=%0b busy=%0b, expected 0 0", l_out_valid, l_busy);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (cyc < 3) begin
            in_valid = 4'hF; in_last = 4'hF;
            for (int c = 0; c < NUM_CH; c++) in_data[c*DW +: DW] = DW'(16'h1000 * (c + 1) + cyc);
         end else begin
            in_valid = '0; in_last = '0;
         end
         step();
         if (cyc >= 1 && cyc <= 12) begin
            n_tests++;
            if (l_out_valid !== 1'b1 || l_out_ch !== CHW'((cyc - 1) % 4) ||
                l_out_data !== DW'(16'h1000 * ((cyc - 1) % 4 + 1) + (cyc - 1) / 4)) begin
               n_fail++;
               $display("[TB] FAIL rr_order cyc=%0d got v=%0b ch=%0d d=%h, expected v=1 ch=%0d", cyc, l_out_valid, l_out_ch, l_out_data, (cyc - 1) % 4);
            end
         end
         n_tests++;
         if (n_out_valid !== m_valid[1] || (m_valid[1] && (n_out_ch !== m_ch[1] || n_out_data !== m_data[1]))) begin
            n_fail++;
            $display("[TB] FAIL rr_model_word cyc=%0d got v=%0b ch=%0d d=%h, expected v=%0b ch=%0d d=%h", cyc, n_out_valid, n_out_ch, n_out_data, m_valid[1], m_ch[1], m_data[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_data = '0; in_last = 4'b0011;
         in_valid = (cyc == 0) ? 4'b0011 : 4'b0010;
         in_data[0 +: DW]  = 16'hC000;
         in_data[DW +: DW] = DW'(16'hD000 + cyc);
         step();
         if (cyc >= 1) begin
            n_tests++;
            if (l_out_valid !== 1'b1 || l_out_ch !== 2'd0 || l_out_data !== 16'hC000) begin
               n_fail++;
               $display("[TB] FAIL bp_hold cyc=%0d got v=%0b ch=%0d d=%h, expected v=1 ch=0 d=c000", cyc, l_out_valid, l_out_ch, l_out_data);
            end
         end
      end
      in_valid = '0; in_last = '0;
      n_tests++;
      if (l_in_ready[1] !== 1'b0 || l_occ[OW +: OW] !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL bp_full got in_ready1=%0b occ1=%0d, expected 0 4", l_in_ready[1], l_occ[OW +: OW]);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         n_tests++;
         if (k < 4 && (l_out_valid !== 1'b1 || l_out_ch !== 2'd1 || l_out_data !== DW'(16'hD000 + k))) begin
            n_fail++;
            $display("[TB] FAIL bp_drain k=%0d got v=%0b ch=%0d d=%h, expected v=1 ch=1 d=%h", k, l_out_valid, l_out_ch, l_out_data, 16'hD000 + k);
         end else if (k == 4 && (l_out_valid !== 1'b0 || l_busy !== 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL bp_empty got v=%0b busy=%0b, expected 0 0", l_out_valid, l_busy);
         end
      end
   endtask

   task automatic test_packet_lock();
      bit lv [8] = '{0, 1, 1, 0, 0, 1, 1, 1};
      int lc [8] = '{0, 0, 0, 0, 0, 0, 3, 3};
      bit nv [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
      int nc [8] = '{0, 0, 3, 0, 3, 0, 0, 0};
      do_reset();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = '0; in_last = '0; in_data = '0;
         if (cyc == 0 || cyc == 1 || cyc == 4) begin
            in_valid[0] = 1'b1;
            in_last[0]  = (cyc == 4);
            in_data[0 +: DW] = DW'(16'h0A00 + cyc);
         end
         if (cyc == 0 || cyc == 1) begin
            in_valid[3] = 1'b1;
            in_last[3]  = 1'b1;
            in_data[3*DW +: DW] = DW'(16'h3B00 + cyc);
         end
         step();
         n_tests++;
         if (l_out_valid !== lv[cyc] || (lv[cyc] && l_out_ch !== CHW'(lc[cyc]))) begin
            n_fail++;
            $display("[TB] FAIL lock_seq edge=%0d got v=%0b ch=%0d, expected v=%0b ch=%0d", cyc + 1, l_out_valid, l_out_ch, lv[cyc], lc[cyc]);
         end
         n_tests++;
         if (n_out_valid !== nv[cyc] || (nv[cyc] && n_out_ch !== CHW'(nc[cyc]))) begin
            n_fail++;
            $display("[TB] FAIL nolock_seq edge=%0d got v=%0b ch=%0d, expected v=%0b ch=%0d", cyc + 1, n_out_valid, n_out_ch, nv[cyc], nc[cyc]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         in_valid = 4'b0010; in_last = 4'b0010; in_data = '0;
         in_data[DW +: DW] = DW'(16'h5100 + cyc);
         step();
      end
      in_valid = '0; in_last = '0;
      n_tests++;
      if (l_out_valid !== 1'b1 || l_occ[OW +: OW] !== 3'd2) begin
         n_fail++;
         $display("[TB] FAIL mid_pre got v=%0b occ1=%0d, expected 1 2", l_out_valid, l_occ[OW +: OW]);
      end
      reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (l_out_valid !== 1'b0 || l_busy !== 1'b0 || l_occ !== '0 || l_in_ready !== 4'hF) begin
         n_fail++;
         $display("[TB] FAIL mid_reset got v=%0b busy=%0b occ=%h rdy=%h, expected 0 0 0 f", l_out_valid, l_busy, l_occ, l_in_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      in_valid = 4'b0011; in_last = 4'b0011;
      in_data = '0; in_data[0 +: DW] = 16'h6000; in_data[DW +: DW] = 16'h6100;
      step();
      in_valid = '0; in_last = '0;
      step();
      n_tests++;
      if (l_out_valid !== 1'b1 || l_out_ch !== 2'd0 || l_out_data !== 16'h6000) begin
         n_fail++;
         $display("[TB] FAIL mid_first_grant got v=%0b ch=%0d d=%h, expected v=1 ch=0 d=6000", l_out_valid, l_out_ch, l_out_data);
      end
   endtask

   task automatic test_random();
      bit exp_busy;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            in_valid[c] = ($urandom_range(0, 99) < 45);
            in_last[c]  = ($urandom_range(0, 2) == 0);
            in_data[c*DW +: DW] = DW'($urandom);
         end
         out_ready = ($urandom_range(0, 99) < 70);
         step();
         n_tests++;
         if (l_out_valid !== m_valid[0] || (m_valid[0] && (l_out_ch !== m_ch[0] || l_out_data !== m_data[0] || l_out_last !== m_last[0]))) begin
            n_fail++;
            $display("[TB] FAIL rand_out_lock cyc=%0d got v=%0b ch=%0d d=%h l=%0b, expected v=%0b ch=%0d d=%h l=%0b", cyc, l_out_valid, l_out_ch, l_out_data, l_out_last, m_valid[0], m_ch[0], m_data[0], m_last[0]);
         end
         n_tests++;
         if (n_out_valid !== m_valid[1] || (m_valid[1] && (n_out_ch !== m_ch[1] || n_out_data !== m_data[1] || n_out_last !== m_last[1]))) begin
            n_fail++;
            $display("[TB] FAIL rand_out_word cyc=%0d got v=%0b ch=%0d d=%h l=%0b, expected v=%0b ch=%0d d=%h l=%0b", cyc, n_out_valid, n_out_ch, n_out_data, n_out_last, m_valid[1], m_ch[1], m_data[1], m_last[1]);
         end
         exp_busy = m_valid[0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (mq[0][c].size() > 0) exp_busy = 1;
            n_tests++;
            if (l_occ[c*OW +: OW] !== OW'(mq[0][c].size()) || l_in_ready[c] !== (mq[0][c].size() < DEPTH) ||
                n_occ[c*OW +: OW] !== OW'(mq[1][c].size())) begin
               n_fail++;
               $display("[TB] FAIL rand_occ cyc=%0d ch=%0d got occ=%0d/%0d rdy=%0b, expected occ=%0d/%0d", cyc, c, l_occ[c*OW +: OW], n_occ[c*OW +: OW], l_in_ready[c], mq[0][c].size(), mq[1][c].size());
            end
         end
         n_tests++;
         if (l_busy !== exp_busy) begin
            n_fail++;
            $display("[TB] FAIL rand_busy cyc=%0d got busy=%0b, expected %0b", cyc, l_busy, exp_busy);
         end
      end
      in_valid = '0;
      out_ready = 1'b1;
   endtask

   initial begin
      in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      test_reset();
      test_single_word();
      test_round_robin();
      test_backpressure();
      test_packet_lock();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_buffer_rr_n.md
Name: edge_buffer_rr_n

Overview:
- Parametrised N-channel edge-result buffer between the edge PEs and the reservation-station (RS) input port.
- Each channel has its own FIFO. A work-conserving round-robin arbiter drains the FIFOs into one registered output stage with valid/ready backpressure.
- An optional packet-lock mode keeps the output on one channel from the first word of a packet until its last word (sos..eos streaming), so packets are never interleaved.

Parameters:
- NUM_CH, 4, number of input channels (edge PEs); must be 2..16.
- DW, 64, payload width per word.
- DEPTH, 4, per-channel FIFO depth; must be a power of 2 and at least 2.
- PKT_LOCK, 1, 1 = hold the grant until a word with last=1 is popped; 0 = arbitrate per word.
- CHW, $clog2(NUM_CH), channel-index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_CH  per-channel push request.
- in_data  in  NUM_CH*DW  per-channel payload; channel i occupies [i*DW +: DW].
- in_last  in  NUM_CH  per-channel end-of-packet flag.
- in_ready  out  NUM_CH  per-channel FIFO not full.
- out_valid  out  1  output word valid.
- out_data  out  DW  output payload.
- out_last  out  1  end-of-packet flag of the output word.
- out_ch  out  CHW  source channel of the output word.
- out_ready  in  1  consumer accepts the word (RS not busy).
- busy  out  1  any FIFO non-empty, or out_valid set.
- occ  out  NUM_CH*($clog2(DEPTH)+1)  per-channel FIFO occupancy.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-low; clock clk.
- Reset state:
  - all FIFOs empty; occ = 0; in_ready = all 1s.
  - out_valid = 0; out_data, out_last, out_ch = 0; busy = 0.
  - rr_ptr = NUM_CH-1, so channel 0 has highest priority first; lock cleared.
  - Reset asserted mid-packet discards all FIFO contents and the held output word.
- Push:
  - Channel i writes when in_valid[i] & in_ready[i].
  - in_ready[i] = (occ[i] != DEPTH), computed from registered occupancy.
  - A full FIFO does not accept a push, even in a cycle where it is popped.
  - Push into a full FIFO is impossible by construction; the bench asserts this.
- Load condition: load = ~out_valid | out_ready.
- Pop:
  - When load=1 and an eligible channel exists, the winner's head word is popped into the output register at the same edge.
  - That edge sets out_valid=1, out_data, out_last and out_ch=winner.
  - Pushing and popping the same FIFO in one cycle leaves occ unchanged.
- Output hold:
  - If load=1 and no channel is eligible, out_valid goes to 0.
  - If out_valid=1 and out_ready=0, out_data, out_last and out_ch hold stable and nothing is popped.
- Eligibility:
  - Unlocked: any non-empty FIFO is eligible.
  - Locked: only lock_ch is eligible. If lock_ch is empty, the output idles even while other channels hold data.
- Arbitration:
  - Search starts at rr_ptr+1 and wraps modulo NUM_CH; the first eligible channel wins.
  - rr_ptr updates to the winner only on an actual pop. Stalled cycles do not advance the pointer.
- Lock FSM (PKT_LOCK=1):
  - States: IDLE and LOCKED(lock_ch).
  - IDLE -> LOCKED on a pop of a word with last=0; lock_ch = winner.
  - LOCKED -> IDLE on a pop of a word from lock_ch with last=1.
  - A single-word packet (last=1) never enters LOCKED.
  - PKT_LOCK=0: the FSM stays in IDLE permanently.
- Latency:
  - A push at edge t makes the FIFO non-empty after t.
  - If the output is free, out_valid=1 after edge t+1 (2-cycle minimum latency).
  - Sustained throughput is 1 word/cycle when out_ready=1.
- FIFO pointers: $clog2(DEPTH) bits with natural wrap; occupancy is a separate counter saturating at 0..DEPTH.
- busy: combinational OR of (occ != 0) over all channels, ORed with out_valid.

Test Plan:
- Single word: reset, then ch2 pushes D=0xA5 with last=1, out_ready=1 -> out_valid=1 two edges after the push, out_ch=2, out_data=0xA5; busy drops the cycle after the pop.
- Round-robin fairness: all 4 channels push 3 words each (last=1) simultaneously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3; no stall cycles.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_ch stable and rr_ptr unchanged. Fill ch1 to DEPTH=4 -> in_ready[1]=0 and occ[1]=4. Release out_ready -> drains in order.
- Packet lock:
  - PKT_LOCK=1, ch0 sends 3 words (last on the 3rd) with a 2-cycle gap before the 3rd; ch3 holds data.
  - Response: ch3 is not granted until ch0's last word pops; out_valid=0 during the gap; ch3 follows immediately.
- Same traffic with PKT_LOCK=0 -> ch3 words interleave with ch0 words.
- Reset mid-stream: assert reset with 2 words in ch1 and out_valid=1 -> immediately out_valid=0, busy=0, occ=0, in_ready all 1s. After release, the first grant goes to ch0 when ch0 and ch1 push together.
